// File: rtl/elastic_pipe_reg_pkg.sv
// elastic_pipe_reg_pkg: shared pipeline state encoding, default widths and control-bundle field offsets
package elastic_pipe_reg_pkg;
  localparam int DEF_DATA_W = 160;
  localparam int DEF_CTRL_W = 12;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam int CTRL_REG_WE = 0;
  localparam int CTRL_MEM_WE = 1;
  localparam int CTRL_JUMP = 2;
  localparam int CTRL_BRANCH = 3;
  localparam int CTRL_ALU_LO = 4;
  localparam int CTRL_ALU_W = 5;
  localparam int CTRL_RES_LO = 9;
  localparam int CTRL_RES_W = 3;
endpackage

// File: rtl/elastic_pipe_reg_slot.sv
// pipe_slot: loadable, clearable {ctrl,data} register
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clear) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: valid/ready pipeline register with optional skid slot and bubble-safe control output
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  localparam int W = DATA_W + CTRL_W;
  logic [1:0] state, state_nxt;
  logic in_fire, out_fire, main_load, skid_load;
  logic [W-1:0] main_q, main_d, skid_q;
  assign out_valid = state != ST_EMPTY;
  // with a skid slot, ready comes from registered state only
  assign in_ready = (SKID != 0) ? (state != ST_FULL) : ((state == ST_EMPTY) | out_ready);
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_comb begin
    main_load = (in_fire & ((state == ST_EMPTY) | out_fire)) | ((state == ST_FULL) & out_fire);
    main_d = (state == ST_FULL) ? skid_q : {in_ctrl, in_data};
    skid_load = (SKID != 0) & in_fire & (state == ST_ONE) & ~out_fire;
    state_nxt = (state == ST_EMPTY) ? (in_fire ? ST_ONE : ST_EMPTY) :
                (state == ST_ONE)   ? ((in_fire & ~out_fire) ? ST_FULL :
                                       (~in_fire & out_fire) ? ST_EMPTY : ST_ONE) :
                (state == ST_FULL)  ? (out_fire ? ST_ONE : ST_FULL) : ST_EMPTY;
  end
  always_ff @(posedge clk)
    if (reset || flush) state <= ST_EMPTY;
    else state <= state_nxt;
  pipe_slot #(.W(W)) u_main (
    .clk(clk), .rst(reset), .clear(flush), .load(main_load), .d(main_d), .q(main_q)
  );
  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.W(W)) u_skid (
        .clk(clk), .rst(reset), .clear(flush), .load(skid_load), .d({in_ctrl, in_data}), .q(skid_q)
      );
    end else begin : g_noskid
      assign skid_q = '0;
    end
  endgenerate
  assign out_data = main_q[DATA_W-1:0];
  // a bubble must never carry a write enable downstream
  assign out_ctrl = out_valid ? main_q[W-1:DATA_W] : '0;
  assign occupancy = state;
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed vectors plus randomized queue-model checking for SKID=1 and SKID=0
module tb_elastic_pipe_reg;
  localparam int DW = 160;
  localparam int CW = 12;
  typedef struct {
    logic fl, iv, ordy;
    logic [15:0] d;
    logic [11:0] c;
    logic e_ov, e_ir;
    logic [1:0] e_occ;
    logic [15:0] e_d;
    logic [11:0] e_c;
    logic chk_d;
  } vec_t;
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  logic clk = 0, reset = 1;
  logic flush1 = 0, iv1 = 0, or1 = 0;
  logic [DW-1:0] d1 = '0;
  logic [CW-1:0] c1 = '0;
  logic ir1, ov1;
  logic [DW-1:0] od1;
  logic [CW-1:0] oc1;
  logic [1:0] occ1;
  logic flush0 = 0, iv0 = 0, or0 = 0;
  logic [DW-1:0] d0 = '0;
  logic [CW-1:0] c0 = '0;
  logic ir0, ov0;
  logic [DW-1:0] od0;
  logic [CW-1:0] oc0;
  logic [1:0] occ0;
  int checks = 0, failures = 0;
  vec_t vecs[15];
  ent_t q1[$], q0[$];
  logic m_ir1, m_ir0, fin1, fout1, fin0, fout0;
  always #5 clk = ~clk;
  elastic_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush1), .in_valid(iv1), .in_ready(ir1), .in_data(d1),
    .in_ctrl(c1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ctrl(oc1), .occupancy(occ1)
  );
  elastic_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush0), .in_valid(iv0), .in_ready(ir0), .in_data(d0),
    .in_ctrl(c0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ctrl(oc0), .occupancy(occ0)
  );
  task automatic chk(input string n, input logic [191:0] a, input logic [191:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  initial begin
    vecs[0]  = '{0, 1, 1, 16'h1,  12'h101, 1, 1, 2'd1, 16'h1,  12'h101, 1};
    vecs[1]  = '{0, 1, 1, 16'h2,  12'h102, 1, 1, 2'd1, 16'h2,  12'h102, 1};
    vecs[2]  = '{0, 1, 1, 16'h3,  12'h103, 1, 1, 2'd1, 16'h3,  12'h103, 1};
    vecs[3]  = '{0, 1, 1, 16'h4,  12'h104, 1, 1, 2'd1, 16'h4,  12'h104, 1};
    vecs[4]  = '{0, 0, 1, 16'h0,  12'h0,   0, 1, 2'd0, 16'h0,  12'h0,   0};
    vecs[5]  = '{0, 1, 0, 16'hA,  12'h5,   1, 1, 2'd1, 16'hA,  12'h5,   1};
    vecs[6]  = '{0, 1, 0, 16'hB,  12'h6,   1, 0, 2'd2, 16'hA,  12'h5,   1};
    vecs[7]  = '{0, 1, 0, 16'hD,  12'h7,   1, 0, 2'd2, 16'hA,  12'h5,   1};
    vecs[8]  = '{0, 0, 1, 16'h0,  12'h0,   1, 1, 2'd1, 16'hB,  12'h6,   1};
    vecs[9]  = '{0, 0, 1, 16'h0,  12'h0,   0, 1, 2'd0, 16'h0,  12'h0,   0};
    vecs[10] = '{0, 1, 0, 16'h21, 12'h21,  1, 1, 2'd1, 16'h21, 12'h21,  1};
    vecs[11] = '{0, 1, 0, 16'h22, 12'h22,  1, 0, 2'd2, 16'h21, 12'h21,  1};
    vecs[12] = '{1, 1, 0, 16'hC,  12'hC,   0, 1, 2'd0, 16'h0,  12'h0,   1};
    vecs[13] = '{0, 0, 1, 16'h0,  12'h0,   0, 1, 2'd0, 16'h0,  12'h0,   0};
    vecs[14] = '{0, 0, 1, 16'h0,  12'h0,   0, 1, 2'd0, 16'h0,  12'h0,   0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", ov1, 0);
    chk("rst_ir", ir1, 1);
    chk("rst_occ", occ1, 0);
    chk("rst_data", od1, 0);
    chk("rst_ctrl", oc1, 0);
    reset = 0;
    // SKID=0: combinational ready follows out_ready, offered entry replaces head
    iv0 = 1; d0 = 'h11; c0 = 'h11; or0 = 0;
    #1 chk("s0_ir_empty", ir0, 1);
    @(posedge clk); #1;
    chk("s0_occ1", occ0, 1);
    chk("s0_head1", od0, 'h11);
    d0 = 'h22; c0 = 'h22;
    #1 chk("s0_ir_stall", ir0, 0);
    @(posedge clk); #1;
    chk("s0_hold", od0, 'h11);
    or0 = 1;
    #1 chk("s0_ir_same_cycle", ir0, 1);
    @(posedge clk); #1;
    chk("s0_replace", od0, 'h22);
    chk("s0_occ_replace", occ0, 1);
    iv0 = 0;
    @(posedge clk); #1;
    chk("s0_drain_occ", occ0, 0);
    chk("s0_drain_ctrl", oc0, 0);
    or0 = 0;
    for (int i = 0; i < 15; i++) begin
      flush1 = vecs[i].fl; iv1 = vecs[i].iv; or1 = vecs[i].ordy;
      d1 = DW'(vecs[i].d); c1 = vecs[i].c;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", i), ov1, vecs[i].e_ov);
      chk($sformatf("v%0d_ir", i), ir1, vecs[i].e_ir);
      chk($sformatf("v%0d_occ", i), occ1, vecs[i].e_occ);
      chk($sformatf("v%0d_ctrl", i), oc1, vecs[i].e_c);
      if (vecs[i].chk_d) chk($sformatf("v%0d_data", i), od1, DW'(vecs[i].e_d));
    end
    flush1 = 0;
    // reset while FULL and stalled, with flush and an offer also asserted
    iv1 = 1; or1 = 0; d1 = 'h31; c1 = 'h31;
    @(posedge clk); #1;
    d1 = 'h32; c1 = 'h32;
    @(posedge clk); #1;
    chk("ms_full", occ1, 2);
    reset = 1; flush1 = 1; d1 = 'h33; c1 = 'h33;
    @(posedge clk); #1;
    chk("ms_data", od1, 0);
    chk("ms_ctrl", oc1, 0);
    chk("ms_ir", ir1, 1);
    chk("ms_occ", occ1, 0);
    reset = 0; flush1 = 0; iv1 = 0;
    q1.delete(); q0.delete();
    for (int n = 0; n < 10000; n++) begin
      iv1 = $urandom_range(0, 3) != 0;
      or1 = $urandom_range(0, 3) != 0;
      flush1 = $urandom_range(0, 63) == 0;
      d1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
      c1 = CW'($urandom);
      iv0 = iv1; or0 = or1; flush0 = flush1; d0 = d1; c0 = c1;
      #1;
      m_ir1 = q1.size() < 2;
      m_ir0 = (q0.size() == 0) || or0;
      chk("r1_ir", ir1, m_ir1);
      chk("r1_ov", ov1, q1.size() > 0);
      chk("r1_occ", occ1, q1.size());
      if (q1.size() > 0) chk("r1_head", {oc1, od1}, q1[0]);
      else chk("r1_bubble_ctrl", oc1, 0);
      chk("r0_ir", ir0, m_ir0);
      chk("r0_ov", ov0, q0.size() > 0);
      chk("r0_occ", occ0, q0.size());
      if (q0.size() > 0) chk("r0_head", {oc0, od0}, q0[0]);
      else chk("r0_bubble_ctrl", oc0, 0);
      fin1 = iv1 & m_ir1; fout1 = or1 & (q1.size() > 0);
      fin0 = iv0 & m_ir0; fout0 = or0 & (q0.size() > 0);
      @(posedge clk);
      if (flush1) q1.delete();
      else begin
        if (fout1) void'(q1.pop_front());
        if (fin1) q1.push_back({c1, d1});
      end
      if (flush0) q0.delete();
      else begin
        if (fout0) void'(q0.pop_front());
        if (fin0) q0.push_back({c0, d0});
      end
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 160, width of the datapath bundle (operands, PC, immediate, register indices).
REQ-002 Parameter CTRL_W, default 12, width of the control bundle (write enables, jump/branch, ALU select, result select).
REQ-003 Parameter SKID, default 1; 1 gives a two-entry skid buffer, 0 gives a single entry with combinational ready.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 flush  input  1  synchronous clear; discards all held entries (branch/jump redirect).
REQ-007 in_valid  input  1  upstream stage presents an entry.
REQ-008 in_ready  output  1  block accepts an entry this cycle.
REQ-009 in_data  input  DATA_W  upstream datapath bundle.
REQ-010 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-011 out_valid  output  1  an entry is presented downstream.
REQ-012 out_ready  input  1  downstream accepts the presented entry.
REQ-013 out_data  output  DATA_W  head-entry datapath bundle.
REQ-014 out_ctrl  output  CTRL_W  head-entry control bundle; all-zero when out_valid=0.
REQ-015 occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 Transfer in occurs when in_valid&in_ready; transfer out occurs when out_valid&out_ready.
REQ-017 An accepted entry appears on out_* in the next cycle, giving a latency of exactly 1 cycle when the block is empty.
REQ-018 With SKID=1, the FSM has states EMPTY, ONE and FULL; occupancy encodes 0, 1 and 2 respectively.
REQ-019 EMPTY: a transfer in loads the main slot and moves the FSM to ONE; with no transfer in it stays EMPTY.
REQ-020 ONE: in+out replaces the main slot and stays ONE; in-only writes the skid slot and moves to FULL; out-only moves to EMPTY; neither holds.
REQ-021 FULL: an out transfer copies skid to main and moves to ONE; with no out transfer it holds.
REQ-022 With SKID=1, in_ready = (state != FULL) and is driven directly from registered state, with no combinational path from out_ready.
REQ-023 With SKID=0, there is no FULL state; in_ready = (state==EMPTY) | out_ready, combinationally.
REQ-024 Entries leave in acceptance order; no entry is duplicated or dropped except by flush or reset.
REQ-025 out_valid = (state != EMPTY); out_data and out_ctrl always present the main slot.
REQ-026 Where out_valid=0, out_ctrl is forced to zero so that a bubble never asserts a write enable.
REQ-027 flush forces EMPTY and zeroes both slots in the next cycle, whatever the state.
REQ-028 flush takes priority over a simultaneous transfer in or out; the incoming entry is dropped.
REQ-029 While out_ready=0 (stall), the main slot, skid slot and state hold unchanged unless in accepts into an empty position.
REQ-030 in_data/in_ctrl are ignored when in_valid=0; the slots do not change.

Reset
REQ-031 reset forces EMPTY, occupancy=0, out_valid=0, and out_data=0 and out_ctrl=0 from the next edge; with SKID=1 it also forces in_ready=1.
REQ-032 reset overrides flush and any handshake, including during a FULL stall.
REQ-033 Both slots are zeroed on reset so that there is no X on out_data.

Structure
REQ-034 The shared pipeline package holds the state encoding (EMPTY=0, ONE=1, FULL=2), the default DATA_W/CTRL_W values and the control-bundle field offsets.
REQ-035 One sub-module, pipe_slot: a loadable, clearable {ctrl,data} register, instantiated for main and for skid (skid only when SKID=1).
REQ-036 The block contains no other logic beyond the FSM and the output forcing.

Verification
REQ-037 Back-to-back flow: in_valid=1 with in_data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later, and occupancy stays 1.
REQ-038 Stall fill (SKID=1): load A=0xA, then out_ready=0, then offer B=0xB -> state FULL, in_ready=0, and out_data stays 0xA; raise out_ready -> A then B appear, and in_ready returns to 1 one cycle after A leaves.
REQ-039 Flush while FULL with in_valid=1 and C=0xC -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and C is never emitted.
REQ-040 Reset mid-stall (FULL, out_ready=0) -> next cycle out_data=0, out_ctrl=0, in_ready=1, occupancy=0.
REQ-041 SKID=0 with out_ready=0 and occupancy=1 -> in_ready=0; toggling out_ready to 1 gives in_ready=1 in the same cycle, and an offered entry replaces the head.
REQ-042 Random valid/ready for 10k cycles -> the scoreboard shows in-order, lossless delivery, out_ctrl==0 whenever out_valid=0, and occupancy never exceeding 1+SKID.
